// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 FSM state encodings, command bytes and parity.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

   typedef logic [3:0] ps2_state_t;

   localparam ps2_state_t ST_IDLE      = 4'd0;
   localparam ps2_state_t ST_INHIBIT   = 4'd1;
   localparam ps2_state_t ST_RTS       = 4'd2;
   localparam ps2_state_t ST_SHIFT     = 4'd3;
   localparam ps2_state_t ST_STOP      = 4'd4;
   localparam ps2_state_t ST_ACK       = 4'd5;
   localparam ps2_state_t ST_WAIT_IDLE = 4'd6;
   localparam ps2_state_t ST_DONE      = 4'd7;
   localparam ps2_state_t ST_ERROR     = 4'd8;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // Odd parity bit: 1 when the byte holds an even number of ones.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command-byte handshake between a requester and ps2_host_tx.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       busy;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_done, tx_error, busy
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_done, tx_error, busy
   );
endinterface

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchroniser for a PS/2 line with falling-edge detect.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_line_sync (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_line,
   output logic      o_sync,
   output logic      o_fell
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Flops reset high to match the idle (pulled-up) line, so no false edge after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_fell = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter: inhibit, RTS, shift, stop, ACK.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned FRAME_TIMEOUT  = 100000
) (
   input  wire logic      clk,
   input  wire logic      reset,
   ps2_host_tx_if.slave   tx_if,
   input  wire logic      ps2_clock_in,
   input  wire logic      ps2_data_in,
   output logic           ps2_clock_oe,
   output logic           ps2_data_oe
);

   localparam int unsigned c_timer_max =
      (INHIBIT_CYCLES > START_TIMEOUT)
         ? ((INHIBIT_CYCLES > FRAME_TIMEOUT) ? INHIBIT_CYCLES : FRAME_TIMEOUT)
         : ((START_TIMEOUT  > FRAME_TIMEOUT) ? START_TIMEOUT  : FRAME_TIMEOUT);
   localparam int c_timer_w = $clog2(c_timer_max);

   localparam logic [c_timer_w-1:0] c_inhibit_load = c_timer_w'(INHIBIT_CYCLES - 1);
   localparam logic [c_timer_w-1:0] c_start_load   = c_timer_w'(START_TIMEOUT - 1);
   localparam logic [c_timer_w-1:0] c_frame_load   = c_timer_w'(FRAME_TIMEOUT - 1);
   localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);

   ps2_state_t           r_state;
   logic [8:0]           r_shift;
   logic [3:0]           r_bit_cnt;
   logic [c_timer_w-1:0] r_timer;
   logic                 r_clock_oe;
   logic                 r_data_oe;
   logic                 r_data_meta;
   logic                 r_data_sync;
   logic                 w_clk_sync;
   logic                 w_clk_fell;
   logic                 w_timer_zero;

   ps2_line_sync u_clock_sync (
      .clk    (clk),
      .reset  (reset),
      .i_line (ps2_clock_in),
      .o_sync (w_clk_sync),
      .o_fell (w_clk_fell)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_data_meta <= ps2_data_in;
         r_data_sync <= r_data_meta;
      end
   end

   assign w_timer_zero = (r_timer == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_timer    <= '0;
         r_clock_oe <= 1'b0;
         r_data_oe  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (tx_if.tx_valid) begin
                  r_shift    <= {odd_parity(tx_if.tx_data), tx_if.tx_data};
                  r_bit_cnt  <= '0;
                  r_timer    <= c_inhibit_load;
                  r_clock_oe <= 1'b1;
                  r_data_oe  <= 1'b0;
                  r_state    <= ST_INHIBIT;
               end
            end

            // Data goes low one cycle before clock is released so RTS is clean.
            ST_INHIBIT: begin
               if (w_timer_zero) begin
                  r_clock_oe <= 1'b0;
                  r_data_oe  <= 1'b1;
                  r_timer    <= c_start_load;
                  r_state    <= ST_RTS;
               end else begin
                  if (r_timer == c_timer_one) begin
                     r_data_oe <= 1'b1;
                  end
                  r_timer <= r_timer - c_timer_one;
               end
            end

            ST_RTS: begin
               if (w_clk_fell) begin
                  r_timer <= c_frame_load;
                  r_state <= ST_SHIFT;
               end else if (w_timer_zero) begin
                  r_clock_oe <= 1'b0;
                  r_data_oe  <= 1'b0;
                  r_state    <= ST_ERROR;
               end else begin
                  r_timer <= r_timer - c_timer_one;
               end
            end

            ST_SHIFT, ST_STOP, ST_ACK, ST_WAIT_IDLE: begin
               if (w_timer_zero) begin
                  r_clock_oe <= 1'b0;
                  r_data_oe  <= 1'b0;
                  r_state    <= ST_ERROR;
               end else begin
                  r_timer <= r_timer - c_timer_one;
                  case (r_state)
                     ST_SHIFT: begin
                        if (w_clk_fell) begin
                           r_data_oe <= ~r_shift[0];
                           r_shift   <= {1'b0, r_shift[8:1]};
                           r_bit_cnt <= r_bit_cnt + 4'd1;
                           if (r_bit_cnt == 4'd8) begin
                              r_state <= ST_STOP;
                           end
                        end
                     end
                     ST_STOP: begin
                        if (w_clk_fell) begin
                           r_data_oe <= 1'b0;
                           r_state   <= ST_ACK;
                        end
                     end
                     ST_ACK: begin
                        if (w_clk_fell) begin
                           r_state <= r_data_sync ? ST_ERROR : ST_WAIT_IDLE;
                        end
                     end
                     default: begin
                        if (r_data_sync && w_clk_sync) begin
                           r_state <= ST_DONE;
                        end
                     end
                  endcase
               end
            end

            ST_DONE, ST_ERROR: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_clock_oe <= 1'b0;
               r_data_oe  <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_if.tx_ready = (r_state == ST_IDLE);
   assign tx_if.busy     = (r_state != ST_IDLE);
   assign tx_if.tx_done  = (r_state == ST_DONE);
   assign tx_if.tx_error = (r_state == ST_ERROR);
   assign ps2_clock_oe   = r_clock_oe;
   assign ps2_data_oe    = r_data_oe;

endmodule

`default_nettype wire
